// File: rtl/mio_pkg.sv
// mio_pkg -- definitions shared by the MIO bus arbiter and its neighbours.
//   MIO_DATA_W   : default data/address width of the MIO bus
//   arb_state_t  : arbiter FSM state encoding (IDLE / ACCESS / DONE)
//   MIO_RGN_*    : MIO address regions, taken from address bits [31:28]
//   mio_region() : extracts the region nibble from a byte address
package mio_pkg;

  localparam int unsigned MIO_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic [3:0] MIO_RGN_RAM   = 4'h0;
  localparam logic [3:0] MIO_RGN_PITCH = 4'h2;
  localparam logic [3:0] MIO_RGN_TIMER = 4'h3;
  localparam logic [3:0] MIO_RGN_GP    = 4'hc;
  localparam logic [3:0] MIO_RGN_PS2   = 4'hd;
  localparam logic [3:0] MIO_RGN_GPIO  = 4'he;
  localparam logic [3:0] MIO_RGN_SW    = 4'hf;

  function automatic logic [3:0] mio_region(input logic [MIO_DATA_W-1:0] addr);
    return addr[MIO_DATA_W-1 -: 4];
  endfunction

endpackage

// File: rtl/mio_arbiter_if.sv
// mio_arbiter_if -- bundles both master request channels and the MIO
// decoder bus of the arbiter.
//   m0_* : CPU channel       (req, we, addr, wdata in; ack, rdata out)
//   m1_* : sequencer DMA     (same shape as m0)
//   bus_addr/bus_wdata/bus_we : to MIO decoder addr / cpu_out / mem_w
//   bus_rdata                 : from MIO decoder cpu_in
// Modports:
//   slave  : the arbiter side
//   master : the side that drives requests and models the decoder
interface mio_arbiter_if #(
  parameter int unsigned DATA_W = mio_pkg::MIO_DATA_W
);

  logic              m0_req;
  logic              m0_we;
  logic [DATA_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [DATA_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [DATA_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output bus_addr, bus_wdata, bus_we
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output bus_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  bus_addr, bus_wdata, bus_we
  );

endinterface

// File: rtl/mio_arbiter.sv
// mio_arbiter -- two-master arbiter in front of the MIO address decoder.
// m0 (CPU) and m1 (sequencer DMA) share one MIO bus. A transaction runs
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ack pulse) -> IDLE, so one
// transaction completes every WAIT_CYCLES+2 cycles under sustained load.
//
// Parameters:
//   WAIT_CYCLES : ACCESS cycles before read capture (1..15)
//   DATA_W      : data/address width (must match the interface)
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   mio   : mio_arbiter_if.slave (master channels + decoder bus)
//   busy  : high in any state other than IDLE
//   owner : index of the current or last granted master (1 after reset)
//
// Build option:
//   MIO_ARB_RR_EN : when defined, contention alternates away from owner
//                   (round-robin); otherwise m0 always wins contention.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DATA_W      = MIO_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  mio_arbiter_if.slave    mio,
  output logic            busy,
  output logic            owner
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  arb_state_t        state_q;
  arb_state_t        state_d;

  logic [3:0]        cnt_q;
  logic              lat_we_q;
  logic [DATA_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              owner_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic              load_en;
  logic              cap_en;
  logic              win;
  logic              in_access;

  // Returns the master to grant; with no request it keeps the last owner
  // so the result is always defined.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
`ifdef MIO_ARB_RR_EN
    if (r0 && r1) return ~last;
    if (r0)       return 1'b0;
    if (r1)       return 1'b1;
    return last;
`else
    if (r0) return 1'b0;
    if (r1) return 1'b1;
    return last;
`endif
  endfunction

  assign win = pick_winner(mio.m0_req, mio.m1_req, owner_q);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mio.m0_req || mio.m1_req) begin
          load_en = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Counter reaches 0 on this edge: leave ACCESS. Read data is
        // captured here, while the decoder still sees the address, so the
        // rdata register already holds it during the DONE/ack cycle.
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
          cap_en  = ~lat_we_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request latch, wait counter and owner
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      owner_q     <= 1'b1;
    end else if (load_en) begin
      cnt_q       <= WAIT_LOAD;
      owner_q     <= win;
      lat_we_q    <= win ? mio.m1_we    : mio.m0_we;
      lat_addr_q  <= win ? mio.m1_addr  : mio.m0_addr;
      lat_wdata_q <= win ? mio.m1_wdata : mio.m0_wdata;
    end else if (state_q == ST_ACCESS) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-master read data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (cap_en) begin
      if (owner_q) begin
        m1_rdata_q <= mio.bus_rdata;
      end else begin
        m0_rdata_q <= mio.bus_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state only, so reset clears the bus
  // strobe without waiting for a clock edge.
  // ---------------------------------------------------------------------
  assign in_access     = (state_q == ST_ACCESS);

  assign mio.bus_addr  = in_access ? lat_addr_q  : '0;
  assign mio.bus_wdata = in_access ? lat_wdata_q : '0;
  // The counter still holds its load value only in the first ACCESS cycle.
  assign mio.bus_we    = in_access && lat_we_q && (cnt_q == WAIT_LOAD);

  assign mio.m0_ack    = (state_q == ST_DONE) && !owner_q;
  assign mio.m1_ack    = (state_q == ST_DONE) &&  owner_q;
  assign mio.m0_rdata  = m0_rdata_q;
  assign mio.m1_rdata  = m1_rdata_q;

  assign busy          = (state_q != ST_IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter -- self-checking bench for mio_arbiter.
// Two instances: WAIT_CYCLES=1 (dut 0) and WAIT_CYCLES=3 (dut 1).
// A transaction-timeline model predicts every output each cycle; directed
// sequences with literal expectations pin the model, then random traffic
// runs on both instances.
module tb_mio_arbiter;

  localparam int unsigned DW = 32;
  localparam int WM [2] = '{1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // bench-side drive values: [dut][master]
  logic          drv_req   [2][2];
  logic          drv_we    [2][2];
  logic [DW-1:0] drv_addr  [2][2];
  logic [DW-1:0] drv_wdata [2][2];
  logic [DW-1:0] drv_brd   [2];

  mio_arbiter_if #(.DATA_W(DW)) if0 ();
  mio_arbiter_if #(.DATA_W(DW)) if1 ();

  logic busy0, busy1, owner0, owner1;

  mio_arbiter #(.WAIT_CYCLES(1), .DATA_W(DW)) dut0 (
    .clk(clk), .rst(rst), .mio(if0.slave), .busy(busy0), .owner(owner0));
  mio_arbiter #(.WAIT_CYCLES(3), .DATA_W(DW)) dut1 (
    .clk(clk), .rst(rst), .mio(if1.slave), .busy(busy1), .owner(owner1));

  assign if0.m0_req = drv_req[0][0];   assign if0.m1_req = drv_req[0][1];
  assign if0.m0_we  = drv_we[0][0];    assign if0.m1_we  = drv_we[0][1];
  assign if0.m0_addr  = drv_addr[0][0];  assign if0.m1_addr  = drv_addr[0][1];
  assign if0.m0_wdata = drv_wdata[0][0]; assign if0.m1_wdata = drv_wdata[0][1];
  assign if0.bus_rdata = drv_brd[0];
  assign if1.m0_req = drv_req[1][0];   assign if1.m1_req = drv_req[1][1];
  assign if1.m0_we  = drv_we[1][0];    assign if1.m1_we  = drv_we[1][1];
  assign if1.m0_addr  = drv_addr[1][0];  assign if1.m1_addr  = drv_addr[1][1];
  assign if1.m0_wdata = drv_wdata[1][0]; assign if1.m1_wdata = drv_wdata[1][1];
  assign if1.bus_rdata = drv_brd[1];

  // observed outputs, indexed by dut
  logic          o_busy  [2];
  logic          o_owner [2];
  logic          o_we    [2];
  logic [DW-1:0] o_addr  [2];
  logic [DW-1:0] o_wdata [2];
  logic          o_ack   [2][2];
  logic [DW-1:0] o_rdata [2][2];

  assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
  assign o_owner[0] = owner0; assign o_owner[1] = owner1;
  assign o_we[0] = if0.bus_we;  assign o_we[1] = if1.bus_we;
  assign o_addr[0] = if0.bus_addr;  assign o_addr[1] = if1.bus_addr;
  assign o_wdata[0] = if0.bus_wdata; assign o_wdata[1] = if1.bus_wdata;
  assign o_ack[0][0] = if0.m0_ack; assign o_ack[0][1] = if0.m1_ack;
  assign o_ack[1][0] = if1.m0_ack; assign o_ack[1][1] = if1.m1_ack;
  assign o_rdata[0][0] = if0.m0_rdata; assign o_rdata[0][1] = if0.m1_rdata;
  assign o_rdata[1][0] = if1.m0_rdata; assign o_rdata[1][1] = if1.m1_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -----------------------------------------------------------------------
  // Reference model: one transaction timeline per dut. pos counts cycles
  // since the sampling edge: 1..W = bus phase, W+1 = ack cycle.
  // -----------------------------------------------------------------------
  logic          m_in_tx [2];
  int            m_pos   [2];
  int            m_who   [2];
  logic          m_we    [2];
  logic [DW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  int            m_owner [2];
  logic [DW-1:0] m_rd    [2][2];

  function automatic int choose(input logic r0, input logic r1, input int last);
    if (r0 && r1) begin
`ifdef MIO_ARB_RR_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_in_tx[d] = 1'b0; m_pos[d] = 0; m_owner[d] = 1;
          m_rd[d][0] = '0;   m_rd[d][1] = '0;
        end else if (m_in_tx[d]) begin
          m_pos[d]++;
          if (m_pos[d] == WM[d] + 1 && !m_we[d]) m_rd[d][m_who[d]] = drv_brd[d];
          if (m_pos[d] > WM[d] + 1) m_in_tx[d] = 1'b0;
        end else if (drv_req[d][0] || drv_req[d][1]) begin
          m_who[d]   = choose(drv_req[d][0], drv_req[d][1], m_owner[d]);
          m_owner[d] = m_who[d];
          m_we[d]    = drv_we[d][m_who[d]];
          m_addr[d]  = drv_addr[d][m_who[d]];
          m_wdata[d] = drv_wdata[d][m_who[d]];
          m_in_tx[d] = 1'b1;
          m_pos[d]   = 1;
        end
      end
    end
  end

  // compare process: every cycle, mid-period, outside reset
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          logic bus_ph;
          bus_ph = m_in_tx[d] && m_pos[d] <= WM[d];
          chk($sformatf("d%0d_busy", d), o_busy[d], m_in_tx[d]);
          chk($sformatf("d%0d_owner", d), o_owner[d], m_owner[d][0]);
          chk($sformatf("d%0d_bus_addr", d), o_addr[d], bus_ph ? m_addr[d] : '0);
          chk($sformatf("d%0d_bus_wdata", d), o_wdata[d], bus_ph ? m_wdata[d] : '0);
          chk($sformatf("d%0d_bus_we", d), o_we[d], m_in_tx[d] && m_pos[d] == 1 && m_we[d]);
          for (int m = 0; m < 2; m++) begin
            chk($sformatf("d%0d_m%0d_ack", d, m), o_ack[d][m],
                m_in_tx[d] && m_pos[d] == WM[d] + 1 && m_who[d] == m);
            chk($sformatf("d%0d_m%0d_rdata", d, m), o_rdata[d][m], m_rd[d][m]);
          end
        end
      end
    end
  end

  // -----------------------------------------------------------------------
  // Directed helper: one transaction on (d, m); cycle 1 is the cycle the
  // request is first sampled. Returns the ack cycle (0 on timeout).
  // -----------------------------------------------------------------------
  task automatic run_one(input int d, input int m, input logic we,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rd, output int ack_cyc,
                         output int we_cnt, output int addr_cnt,
                         output logic [DW-1:0] wd_seen);
    drv_req[d][m] = 1'b1; drv_we[d][m] = we;
    drv_addr[d][m] = addr; drv_wdata[d][m] = wdata; drv_brd[d] = rd;
    ack_cyc = 0; we_cnt = 0; addr_cnt = 0; wd_seen = '0;
    for (int k = 1; k <= 20 && ack_cyc == 0; k++) begin
      @(negedge clk);
      if (o_we[d]) begin we_cnt++; wd_seen = o_wdata[d]; end
      if (o_addr[d] == addr && o_busy[d]) addr_cnt++;
      if (o_ack[d][m]) ack_cyc = k + 1;
    end
    drv_req[d][m] = 1'b0;
  endtask

  int ack_cyc, we_cnt, addr_cnt, n_gr, idle_act;
  logic [DW-1:0] wd_seen;
  int grants [4];
  int exp_gr [4];

  initial begin
    for (int d = 0; d < 2; d++) begin
      drv_brd[d] = '0;
      for (int m = 0; m < 2; m++) begin
        drv_req[d][m] = 1'b0; drv_we[d][m] = 1'b0;
        drv_addr[d][m] = '0;  drv_wdata[d][m] = '0;
      end
    end
    repeat (3) @(negedge clk);
    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", o_busy[d], 0);
      chk("rst_owner", o_owner[d], 1);
      chk("rst_bus_we", o_we[d], 0);
      chk("rst_bus_addr", o_addr[d], 0);
      chk("rst_rdata0", o_rdata[d][0], 0);
      chk("rst_rdata1", o_rdata[d][1], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // m0 read of 0x10
    run_one(0, 0, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, ack_cyc, we_cnt, addr_cnt, wd_seen);
    chk("rd_ack_cycle", ack_cyc, 3);
    chk("rd_addr_cycles", addr_cnt, 1);
    chk("rd_m0_rdata", o_rdata[0][0], 32'hDEAD_BEEF);
    chk("rd_m1_rdata", o_rdata[0][1], 0);
    chk("rd_owner", o_owner[0], 0);
    @(negedge clk);
    chk("rd_after_addr", o_addr[0], 0);
    chk("rd_after_busy", o_busy[0], 0);

    // m1 write 0xABCD to 0xE0000000
    run_one(0, 1, 1'b1, 32'hE000_0000, 32'h0000_ABCD, 32'h1111_2222, ack_cyc, we_cnt, addr_cnt, wd_seen);
    chk("wr_ack_cycle", ack_cyc, 3);
    chk("wr_we_pulses", we_cnt, 1);
    chk("wr_wdata", wd_seen, 32'h0000_ABCD);
    chk("wr_m0_rdata", o_rdata[0][0], 32'hDEAD_BEEF);
    chk("wr_m1_rdata", o_rdata[0][1], 0);
    @(negedge clk);

    // contention from reset, both held through 4 transactions
    rst = 1'b1;
    drv_req[0][0] = 1'b1; drv_req[0][1] = 1'b1;
    drv_addr[0][0] = 32'h100; drv_addr[0][1] = 32'h200;
    drv_we[0][0] = 1'b0; drv_we[0][1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_gr = 0;
    for (int k = 0; k < 40 && n_gr < 4; k++) begin
      @(negedge clk);
      drv_brd[0] = $urandom;
      if (o_ack[0][0]) begin grants[n_gr] = 0; n_gr++; end
      else if (o_ack[0][1]) begin grants[n_gr] = 1; n_gr++; end
    end
    drv_req[0][0] = 1'b0; drv_req[0][1] = 1'b0;
`ifdef MIO_ARB_RR_EN
    exp_gr = '{0, 1, 0, 1};
`else
    exp_gr = '{0, 0, 0, 0};
`endif
    chk("contend_count", n_gr, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contend_grant%0d", i), grants[i], exp_gr[i]);
    repeat (2) @(negedge clk);

    // m0 drops req one cycle into ACCESS
    drv_req[0][0] = 1'b1; drv_we[0][0] = 1'b0; drv_addr[0][0] = 32'h44; drv_brd[0] = 32'h0BAD_CAFE;
    @(negedge clk);
    drv_req[0][0] = 1'b0;
    ack_cyc = 0;
    for (int k = 2; k <= 10 && ack_cyc == 0; k++) begin
      @(negedge clk);
      if (o_ack[0][0]) ack_cyc = k + 1;
    end
    chk("drop_ack_cycle", ack_cyc, 3);
    chk("drop_rdata", o_rdata[0][0], 32'h0BAD_CAFE);
    idle_act = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_busy[0] || o_we[0] || o_addr[0] != 0) idle_act++;
    end
    chk("drop_idle_after", idle_act, 0);

    // reset during ACCESS of a write
    drv_req[0][0] = 1'b1; drv_we[0][0] = 1'b1;
    drv_addr[0][0] = 32'h20; drv_wdata[0][0] = 32'h55;
    @(negedge clk);
    chk("abort_we_before", o_we[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_now", o_we[0], 0);
    chk("abort_busy", o_busy[0], 0);
    chk("abort_owner", o_owner[0], 1);
    drv_req[0][0] = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", o_ack[0][0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_ack_after", o_ack[0][0], 0);
    run_one(0, 1, 1'b0, 32'hF000_0000, '0, 32'h0000_00F0, ack_cyc, we_cnt, addr_cnt, wd_seen);
    chk("abort_next_ack", ack_cyc, 3);
    chk("abort_next_rdata", o_rdata[0][1], 32'h0000_00F0);
    @(negedge clk);

    // WAIT_CYCLES=3, m1 read
    run_one(1, 1, 1'b0, 32'h3000_0004, '0, 32'h1234_5678, ack_cyc, we_cnt, addr_cnt, wd_seen);
    chk("w3_ack_cycle", ack_cyc, 5);
    chk("w3_addr_cycles", addr_cnt, 3);
    chk("w3_m1_rdata", o_rdata[1][1], 32'h1234_5678);
    @(negedge clk);

    // random traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        drv_brd[d] = $urandom;
        for (int m = 0; m < 2; m++) begin
          if ((o_ack[d][m] && $urandom_range(1, 0) == 1) ||
              (!drv_req[d][m] && $urandom_range(3, 0) == 0)) begin
            drv_req[d][m] = 1'b1;
            drv_we[d][m] = 1'($urandom_range(1, 0));
            drv_addr[d][m] = $urandom;
            drv_wdata[d][m] = $urandom;
          end else if (o_ack[d][m] || (drv_req[d][m] && $urandom_range(31, 0) == 0)) begin
            drv_req[d][m] = 1'b0;
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      drv_req[d][0] = 1'b0; drv_req[d][1] = 1'b0;
    end
    repeat (10) @(negedge clk);
    chk("final_idle0", o_busy[0], 0);
    chk("final_idle1", o_busy[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, bus cycles held in ACCESS before read capture (legal 1..15).
REQ-002 SHALL have parameter DATA_W, default 32, data and address width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req / m1_req  in  1  transaction request; m0 = CPU, m1 = sequencer DMA.
REQ-006 SHALL have ports m0_we / m1_we  in  1  write (1) or read (0).
REQ-007 SHALL have ports m0_addr / m1_addr  in  DATA_W  byte address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-009 SHALL have ports m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata / m1_rdata  out  DATA_W  registered read data, valid from ack onward.
REQ-011 SHALL have ports bus_addr, bus_wdata  out  DATA_W  and bus_we  out  1, driving the MIO decoder addr, cpu_out and mem_w inputs.
REQ-012 SHALL have port bus_rdata  in  DATA_W, from the MIO decoder cpu_in output.
REQ-013 SHALL have port busy  out  1, high in any state other than IDLE.
REQ-014 SHALL have port owner  out  1, index of the current or last granted master.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-016 IDLE: when either req is high, the block SHALL choose a winner, latch its we/addr/wdata into registers, load the wait counter with WAIT_CYCLES, and move to ACCESS.
REQ-017 ACCESS: bus_addr/bus_wdata SHALL come from the latched values; bus_we SHALL equal the latched we in the first ACCESS cycle only; the counter SHALL decrement each cycle; on the cycle it reaches 0 the FSM SHALL move to DONE.
REQ-018 DONE: on a read, the winner's rdata SHALL load bus_rdata; the winner's ack SHALL pulse for that one cycle; the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be WAIT_CYCLES+2 cycles from the sampled req to ack (3 cycles at default), with exactly one bus_we pulse per write.
REQ-020 Outside ACCESS, bus_addr, bus_wdata and bus_we SHALL be 0.
REQ-021 A non-winning master's rdata SHALL stay unchanged, and a write SHALL leave both rdata registers unchanged.
REQ-022 A requester SHALL hold req/we/addr/wdata until ack; the arbiter samples inputs only in IDLE.
REQ-023 If req falls mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-024 If req is still high in the cycle after ack, it SHALL be treated as a new request.
REQ-025 The block SHALL insert one IDLE cycle between back-to-back transactions, so sustained throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-026 When both reqs are high in IDLE, the master not equal to owner SHALL win (round-robin); when only one req is high, that master SHALL win.
REQ-027 owner SHALL update on entry to ACCESS.

Reset
REQ-028 rst SHALL force IDLE, all outputs 0 except owner = 1 (so m0 wins the first contention), rdata registers 0, counter 0.
REQ-029 Reset mid-transaction SHALL abort the transaction with no ack, and bus_we SHALL drop immediately (asynchronously).

Configuration
REQ-030 With MIO_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-026.
REQ-031 Without MIO_ARB_RR_EN, arbitration SHALL be fixed priority with m0 always winning contention; owner still reports the winner.

Structure
REQ-032 A shared package mio_pkg SHALL hold the FSM state encoding, the MIO address-region constants (RAM 0x0, PITCH 0x2, TIMER 0x3, GP 0xc, PS2 0xd, GPIO 0xe, SW 0xf) and the DATA_W default.
REQ-033 The block SHALL be a single module with no sub-module; the arbitration choice SHALL be a local combinational function.

Verification
REQ-034 Reset, then m0 reads addr 0x00000010 with bus_rdata=0xDEADBEEF: bus_addr=0x10 for 1 cycle, m0_ack on cycle 3, m0_rdata=0xDEADBEEF, m1_rdata=0.
REQ-035 m1 writes 0x0000ABCD to 0xE0000000: bus_we high exactly 1 cycle with bus_wdata=0xABCD, m1_ack on cycle 3, both rdata unchanged.
REQ-036 Both req high from reset, held through 4 transactions: grants m0,m1,m0,m1 with RR enabled; m0,m0,m0,m0 without.
REQ-037 m0 drops req one cycle after IDLE->ACCESS: m0_ack still pulses, then busy=0 with no further bus activity.
REQ-038 Assert rst during ACCESS of a write: bus_we=0 immediately, no ack, owner=1, and the next request completes normally.
REQ-039 WAIT_CYCLES=3, m1 read: bus_addr held 3 cycles, m1_ack 5 cycles after req.
